// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile - ToruMIPS general-purpose register file
//
// 32 x 32-bit registers. There are two combinational read ports for decode and
// one synchronous write port driven from write-back. Register $0 is hardwired
// to zero.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a write in the current cycle is forwarded
//                       to any enabled read port that reads the same non-zero
//                       index. When undefined, such a read returns the old
//                       value, and the new value is visible after the edge.
//
// Parameters:
//   DATA_W - register width (RegBus)
//   ADDR_W - register index width (RegAddrBus)
//   NREG   - number of registers; must equal 2**ADDR_W
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - synchronous reset, active low
//   we     - write enable
//   waddr  - write register index (index 0 is dropped)
//   wdata  - write data
//   re1    - read port 1 enable
//   raddr1 - read port 1 index
//   rdata1 - read port 1 data (0 in reset, when disabled, or for $0)
//   re2    - read port 2 enable
//   raddr2 - read port 2 index
//   rdata2 - read port 2 data (same rules as port 1)
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Write port. $0 is forced to zero here so that it can never hold anything
  // else, whatever is presented on the write port.
  always_comb begin
    // NOTE: the whole array gets a default before the conditional update.
    // Without that default, an incomplete assignment in always_comb infers latches.
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // NOTE: this storage has a reset because one low cycle of rst must clear
  // every register. For that reason the array is built from flops and not
  // from a RAM macro, which cannot be cleared in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses only non-blocking assignments.
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Same-cycle forwarding. The checks for rst, enable and index 0 come first
  // in the read muxes below, so a hit only has to compare indices here.
  logic byp1_hit;
  logic byp2_hit;

`ifdef REGFILE_BYPASS_EN
  assign byp1_hit = we && (waddr == raddr1);
  assign byp2_hit = we && (waddr == raddr2);
`else
  assign byp1_hit = 1'b0;
  assign byp2_hit = 1'b0;
`endif

  // Read port 1: the conditions are tested in priority order.
  always_comb begin
    rdata1 = '0;
    if (!rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (byp1_hit) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  // Read port 2: uses the same rules as port 1 and is fully independent of it.
  always_comb begin
    rdata2 = '0;
    if (!rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (byp2_hit) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

endmodule
